addsub_pipe_32: RTL and testbench
=================================

ADDSUB_PIPE_32 -- requirements
Module: addsub_pipe_32

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port clr_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operand set on A/B/sub is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts the operand set this cycle.
REQ-005 SHALL have port A, input, 32 bits: first operand.
REQ-006 SHALL have port B, input, 32 bits: second operand.
REQ-007 SHALL have port sub, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-008 SHALL have port out_valid, output, 1 bit: S/C_out/flags hold a valid result.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream (Z register load) accepts the result.
REQ-010 SHALL have port S, output, 32 bits: sum/difference, modulo 2^32.
REQ-011 SHALL have port C_out, output, 1 bit: carry out of bit 31.
REQ-012 SHALL have ports V, Z, N, output, 1 bit each: overflow, zero, negative; present only per REQ-030.

Function
REQ-013 SHALL compute S = A + (B XOR {32{sub}}) + sub using 4-bit carry-lookahead groups with group generate/propagate.
REQ-014 SHALL split the computation into two registered stages: stage 1 resolves bits 15:0 and the bit-16 carry; stage 2 resolves bits 31:16 from that carry.
REQ-015 Stage 1 SHALL register low sum[15:0], carry c16, A[31:16], inverted-or-not B[31:16], and a valid bit.
REQ-016 Stage 2 (output register) SHALL load when !out_valid || out_ready; the load drives S, C_out, flags and sets out_valid = stage-1 valid.
REQ-017 Stage 1 SHALL load when !s1_valid || stage 2 loads; in_ready SHALL equal this condition, combinationally.
REQ-018 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-019 Latency SHALL be 2 cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-020 With out_ready=0, out_valid and S/C_out/flags SHALL hold stable; at most 2 operand sets buffered; in_ready deasserts when both stages are full.
REQ-021 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-022 Simultaneous output transfer and input transfer on a full pipe SHALL advance both stages in the same cycle.
REQ-023 C_out SHALL be raw carry; for sub=1, C_out=1 means no borrow.
REQ-024 A 16-bit carry crossing from stage 1 to stage 2 SHALL be exact, including all-ones propagate chains.

Reset
REQ-025 clr_n=0 SHALL immediately clear s1_valid, out_valid, S, C_out, V, Z, N to 0, independent of clk.
REQ-026 in_ready SHALL be 1 while in reset and on the first cycle after reset release.
REQ-027 Reset mid-operation SHALL discard all in-flight results; no result emerges after release unless a new input is transferred.
REQ-028 Data-only pipeline registers MAY be left un-reset; valid bits SHALL be reset.

Configuration
REQ-029 Macro ADDSUB_FLAGS_EN SHALL control flag generation.
REQ-030 With ADDSUB_FLAGS_EN defined: ports V, Z, N SHALL exist; V = (A31 == Bx31) && (S31 != A31) with Bx = B XOR sub; Z = (S == 0); N = S31; registered with S.
REQ-031 Without ADDSUB_FLAGS_EN: ports V, Z, N and their logic SHALL be absent; S/C_out timing unchanged.

Verification
REQ-032 Reset: clr_n=0 mid-stream with 2 results in flight -> out_valid=0, S=0 immediately; in_ready=1; no stale output after release.
REQ-033 A=5, B=3, sub=0, out_ready=1 -> 2 cycles later out_valid=1, S=0x00000008, C_out=0.
REQ-034 A=0x0000FFFF, B=1, sub=0 -> S=0x00010000, C_out=0; A=0xFFFFFFFF, B=1 -> S=0, C_out=1, Z=1.
REQ-035 A=3, B=5, sub=1 -> S=0xFFFFFFFE, C_out=0, N=1; A=0x7FFFFFFF, B=1, sub=0 -> S=0x80000000, V=1, N=1.
REQ-036 out_ready=0, in_valid=1 with 3 back-to-back inputs (1+1, 2+2, 3+3) -> in_ready drops after 2 accepted; on out_ready=1, outputs 2, 4, then 6 accepted and emitted in order.
REQ-037 Without ADDSUB_FLAGS_EN, rerun REQ-033..036 -> identical S/C_out values and timing.

Source files
------------

// File: rtl/addsub_pipe_32.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pipe_32
//  Description : Two-stage pipelined 32-bit adder/subtractor built from
//                4-bit carry-lookahead groups with a second lookahead level
//                over group generate/propagate. Stage 1 resolves bits 15:0
//                and the carry into bit 16; stage 2 resolves bits 31:16.
//                Valid/ready handshake on both sides, full throughput.
//                Optional flags (V, Z, N) are built when ADDSUB_FLAGS_EN
//                is defined; otherwise those ports and logic are absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe_32 (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] S,
    output logic        C_out
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic        V,
    output logic        Z,
    output logic        N
`endif
);

    // Four-way lookahead: carries 0..4 from generate/propagate and carry-in.
    // Used both inside a 4-bit group and across the four groups of a half.
    function automatic logic [4:0] carries4(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c0);
        return c;
    endfunction

    // 16-bit adder: returns {carry_out, sum[15:0]}.
    function automatic logic [16:0] add16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic        cin);
        logic [3:0]  gg;
        logic [3:0]  pg;
        logic [4:0]  gc;
        logic [4:0]  t;
        logic [3:0]  g4;
        logic [3:0]  p4;
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            g4    = a[4*i +: 4] & b[4*i +: 4];
            p4    = a[4*i +: 4] ^ b[4*i +: 4];
            t     = carries4(g4, p4, 1'b0);
            gg[i] = t[4];
            pg[i] = &p4;
        end
        gc = carries4(gg, pg, cin);
        for (int i = 0; i < 4; i++) begin
            g4          = a[4*i +: 4] & b[4*i +: 4];
            p4          = a[4*i +: 4] ^ b[4*i +: 4];
            t           = carries4(g4, p4, gc[i]);
            s[4*i +: 4] = p4 ^ t[3:0];
        end
        return {gc[4], s};
    endfunction

    // Stage-1 registers
    logic        s1_valid;
    logic [15:0] s1_sum_lo;
    logic        s1_c16;
    logic [15:0] s1_a_hi;
    logic [15:0] s1_bx_hi;

    // Handshake: output stage moves when empty or drained; stage 1 moves
    // when empty or when its content is being taken by the output stage.
    logic s2_load;
    logic s1_load;
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Operand B conditionally inverted; sub also serves as the carry-in.
    logic [31:0] bx;
    logic [16:0] lo_res;
    logic [16:0] hi_res;
    assign bx     = B ^ {32{sub}};
    assign lo_res = add16(A[15:0], bx[15:0], sub);
    assign hi_res = add16(s1_a_hi, s1_bx_hi, s1_c16);

    // Stage 1 valid bit
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 data (not reset; qualified by s1_valid)
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_sum_lo <= lo_res[15:0];
            s1_c16    <= lo_res[16];
            s1_a_hi   <= A[31:16];
            s1_bx_hi  <= bx[31:16];
        end
    end

    // Output stage: holds result stable while downstream stalls
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_valid <= 1'b0;
            S         <= 32'd0;
            C_out     <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                S     <= {hi_res[15:0], s1_sum_lo};
                C_out <= hi_res[16];
            end
        end
    end

`ifdef ADDSUB_FLAGS_EN
    // Flags registered alongside S, computed from the same stage-2 operands
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            V <= 1'b0;
            Z <= 1'b0;
            N <= 1'b0;
        end else if (s2_load && s1_valid) begin
            V <= (s1_a_hi[15] == s1_bx_hi[15]) && (hi_res[15] != s1_a_hi[15]);
            Z <= ({hi_res[15:0], s1_sum_lo} == 32'd0);
            N <= hi_res[15];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_pipe_32
//  Description : Self-checking bench for addsub_pipe_32. A queue-based
//                arithmetic model tracks accepted operand sets; a negedge
//                monitor compares every emitted result, the in_ready rule
//                and hold stability. Directed cases pin literal values.
//                Flag checks compile in when ADDSUB_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe_32;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] S;
    logic        C_out;
`ifdef ADDSUB_FLAGS_EN
    logic        V;
    logic        Z;
    logic        N;
`endif

    addsub_pipe_32 dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C_out     (C_out)
`ifdef ADDSUB_FLAGS_EN
        ,
        .V         (V),
        .Z         (Z),
        .N         (N)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected result word: {n, z, v, c, s[31:0]}
    logic [35:0] q[$];
    bit          monitor_en = 1'b0;
    bit          prev_hold = 1'b0;

    function automatic logic [35:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sb);
        logic [31:0] bxm;
        logic [32:0] sum;
        logic        v;
        bxm = b ^ {32{sb}};
        sum = {1'b0, a} + {1'b0, bxm} + {32'd0, sb};
        v   = (a[31] == bxm[31]) && (sum[31] != a[31]);
        return {sum[31], (sum[31:0] == 32'd0), v, sum[32], sum[31:0]};
    endfunction

    task automatic check(input string name, input logic [35:0] act,
                         input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] dut_word();
        logic [35:0] w;
        w = {4'd0, S};
        w[32] = C_out;
`ifdef ADDSUB_FLAGS_EN
        w[35] = N;
        w[34] = Z;
        w[33] = V;
`endif
        return w;
    endfunction

    function automatic logic [35:0] mask_flags(input logic [35:0] w);
`ifdef ADDSUB_FLAGS_EN
        return w;
`else
        return {3'b000, w[32:0]};
`endif
    endfunction

    // Per-cycle monitor: ready rule, result order/values, hold stability
    always @(negedge clk) begin
        if (monitor_en && clr_n) begin
            check("in_ready_rule", {35'd0, in_ready},
                  {35'd0, (out_ready || (q.size() < 2))});
            if (prev_hold) begin
                check("hold_valid", {35'd0, out_valid}, 36'd1);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 36'd1, 36'd0);
                end else begin
                    check("result", dut_word(), mask_flags(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            if (in_valid && in_ready) q.push_back(model(A, B, sub));
        end
    end

    // Single transfer with literal expectations and latency measurement
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic sb, input logic [35:0] exp,
                           input string name);
        int lat;
        @(posedge clk); #1;
        A = a; B = b; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, {35'd0, in_ready}, 36'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({name, "_latency"}, 36'(lat), 36'd2);
        check({name, "_value"}, dut_word(), mask_flags(exp));
    endtask

    initial begin
        int idx;
        int got;
        logic [31:0] outs[3];
        // Reset state
        #12;
        check("reset_out_valid", {35'd0, out_valid}, 36'd0);
        check("reset_S", {4'd0, S}, 36'd0);
        check("reset_in_ready", {35'd0, in_ready}, 36'd1);
        @(posedge clk); #1;
        clr_n = 1'b1;
        monitor_en = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", {35'd0, in_ready}, 36'd1);

        // Model pins
        check("model_5p3", model(32'd5, 32'd3, 1'b0), {4'b0000, 32'd8});
        check("model_3m5", model(32'd3, 32'd5, 1'b1), {4'b1000, 32'hFFFFFFFE});

        // Directed literal cases ({N,Z,V,C,S})
        run_one(32'd5, 32'd3, 1'b0, {4'b0000, 32'h00000008}, "add5_3");
        run_one(32'h0000FFFF, 32'd1, 1'b0, {4'b0000, 32'h00010000}, "c16_chain");
        run_one(32'hFFFFFFFF, 32'd1, 1'b0, {4'b0101, 32'h00000000}, "wrap_zero");
        run_one(32'd3, 32'd5, 1'b1, {4'b1000, 32'hFFFFFFFE}, "sub3_5");
        run_one(32'h7FFFFFFF, 32'd1, 1'b0, {4'b1010, 32'h80000000}, "ovf");
        run_one(32'd7, 32'd7, 1'b1, {4'b0101, 32'h00000000}, "sub_equal");

        // Backpressure: three back-to-back inputs with downstream stalled
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            A = 32'(idx + 1); B = 32'(idx + 1); sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            got = int'(in_ready);
            @(posedge clk); #1;
            if (got == 1) idx++;
        end
        check("bp_accepted", 36'(idx), 36'd2);
        @(negedge clk);
        check("bp_in_ready_low", {35'd0, in_ready}, 36'd0);
        check("bp_hold_S", {4'd0, S}, 36'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                outs[got] = S;
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (idx >= 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_count", 36'(got), 36'd3);
        check("bp_out0", {4'd0, outs[0]}, 36'd2);
        check("bp_out1", {4'd0, outs[1]}, 36'd4);
        check("bp_out2", {4'd0, outs[2]}, 36'd6);

        // Randomized traffic with random backpressure
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sub       = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: begin A = $urandom; B = $urandom; end
                1: begin A = {$urandom_range(0, 65535) > 0 ? 16'h0 : 16'hFFFF, 16'hFFFF};
                         B = 32'($urandom_range(0, 2)); end
                2: begin A = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                         B = 32'($urandom_range(0, 4)); end
                default: begin A = {$urandom} & 32'h8000FFFF; B = $urandom; end
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 36'(q.size()), 36'd0);

        // Reset with two results in flight
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; A = 32'd10; B = 32'd20; sub = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        in_valid = 1'b0;
        monitor_en = 1'b0;
        clr_n = 1'b0;
        #1;
        check("midrst_out_valid", {35'd0, out_valid}, 36'd0);
        check("midrst_S", {4'd0, S}, 36'd0);
        check("midrst_in_ready", {35'd0, in_ready}, 36'd1);
        q.delete();
        prev_hold = 1'b0;
        @(posedge clk); #1;
        clr_n = 1'b1;
        out_ready = 1'b1;
        monitor_en = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            check("no_stale", {35'd0, out_valid}, 36'd0);
        end
        run_one(32'h1234FFFF, 32'h00000001, 1'b0, {4'b0000, 32'h12350000}, "after_rst");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
